div_unit: RTL

Multi-cycle 32-bit integer divider for the CPU execute stage, complementing the ALU's single-cycle multiply with the inverse operation. It accepts a dividend/divisor pair through a START/BUSY/DONE handshake and runs a radix-2 restoring algorithm, one quotient bit per cycle. After a fixed latency it returns a registered quotient and remainder in signed or unsigned mode. The execute stage stalls on BUSY and writes back QUO or REM when DONE pulses.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  // Quotient reported when the divisor is zero (all ones, in both modes).
  localparam logic [DIV_WIDTH-1:0] DIV0_QUO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Magnitude of a possibly negative operand; the most negative value
  // comes back as unsigned 2^31, which the datapath handles naturally.
  function automatic logic [DIV_WIDTH-1:0] divMag(input logic isNeg,
                                                  input logic [DIV_WIDTH-1:0] value);
    divMag = isNeg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the shifted remainder is large enough.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic [DIV_WIDTH:0]   o_rem,
  output logic                 o_qbit
);

  logic [DIV_WIDTH+1:0] w_shift;
  logic [DIV_WIDTH:0]   w_trial;
  logic                 w_ge;

  // Shift, trial-subtract and restore in one combinational pass.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_ge    = (w_shift >= {2'b00, i_divisor});
    w_trial = w_shift[DIV_WIDTH:0] - {1'b0, i_divisor};
    o_qbit  = w_ge;
    o_rem   = w_ge ? w_trial : w_shift[DIV_WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider with START/BUSY/DONE handshake,
// signed and unsigned modes, and registered quotient/remainder outputs.
module div_unit
  import div_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic [DIV_WIDTH-1:0] i_arg0,
  input  logic [DIV_WIDTH-1:0] i_arg1,
  output logic [DIV_WIDTH-1:0] o_quo,
  output logic [DIV_WIDTH-1:0] o_rem,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_div0
);

  div_state_t r_state;
  div_state_t w_next_state;

  logic [4:0]           r_count;
  logic [DIV_WIDTH:0]   r_prem;
  logic [DIV_WIDTH-1:0] r_dvd;
  logic [DIV_WIDTH-1:0] r_dsr;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [DIV_WIDTH-1:0] r_quo;
  logic [DIV_WIDTH-1:0] r_rem;
  logic                 r_div0;
  logic                 r_done;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [DIV_WIDTH-1:0] w_a_mag;
  logic [DIV_WIDTH-1:0] w_b_mag;
  logic [DIV_WIDTH:0]   w_step_rem;
  logic                 w_step_qbit;
  logic                 w_last_iter;

  assign w_a_neg     = i_signed & i_arg0[DIV_WIDTH-1];
  assign w_b_neg     = i_signed & i_arg1[DIV_WIDTH-1];
  assign w_a_mag     = divMag(w_a_neg, i_arg0);
  assign w_b_mag     = divMag(w_b_neg, i_arg1);
  assign w_last_iter = (r_count == 5'(DIV_ITER - 1));

  div_step u_step (
    .i_rem     (r_prem),
    .i_bit     (r_dvd[DIV_WIDTH-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_qbit)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: accept a request, iterate DIV_ITER times, then fix up.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start)     w_next_state = CALC;
      CALC:    if (w_last_iter) w_next_state = FIX;
      FIX:                      w_next_state = IDLE;
      default:                  w_next_state = IDLE;
    endcase
  end

  // Output logic: busy covers every non-idle state, including FIX.
  always_comb begin
    o_busy = (r_state != IDLE);
  end

  // Datapath: operand capture, per-cycle iteration and sign-corrected results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_prem  <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_count <= '0;
            r_prem  <= '0;
            r_dvd   <= w_a_mag;
            r_dsr   <= w_b_mag;
            r_neg_q <= i_signed & (i_arg0[DIV_WIDTH-1] ^ i_arg1[DIV_WIDTH-1])
                       & (i_arg1 != '0);
            r_neg_r <= w_a_neg;
          end
        end
        CALC: begin
          r_prem  <= w_step_rem;
          r_dvd   <= {r_dvd[DIV_WIDTH-2:0], w_step_qbit};
          r_count <= r_count + 5'd1;
        end
        FIX: begin
          if (r_dsr == '0) r_quo <= DIV0_QUO;
          else             r_quo <= r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
          r_rem  <= r_neg_r ? (~r_prem[DIV_WIDTH-1:0] + 32'd1) : r_prem[DIV_WIDTH-1:0];
          r_div0 <= (r_dsr == '0);
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
  assign o_div0 = r_div0;
  assign o_done = r_done;

endmodule
